// File: rtl/shift_right_seq.sv
// shift_right_seq: multi-cycle right shifter, one bit per clock, logical or arithmetic fill
// Ports: clk, rst_n (async active-low); start/din/amt/arith sampled in IDLE;
//        dout result register (updated on entry to DONE), busy (SHIFT or DONE), done (1-cycle pulse).
module shift_right_seq #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] amt,
  input  logic             arith,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done
);
  // counter wide enough to hold both any amt and WIDTH itself, so the clamp never wraps
  localparam int CW = (AMT_W > $clog2(WIDTH + 1)) ? AMT_W : $clog2(WIDTH + 1);
  localparam logic [CW-1:0] W_C = CW'(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sr, sr_nx;
  logic fill, fill_nx;
  logic [CW-1:0] cnt, cnt_nx, amt_c, cnt_ld;
  assign amt_c = CW'(amt);
  assign cnt_ld = (amt_c > W_C) ? W_C : amt_c;
  always_comb begin
    state_nx = state;
    sr_nx = sr;
    fill_nx = fill;
    cnt_nx = cnt;
    case (state)
      IDLE: if (start) begin
        sr_nx = din;
        fill_nx = arith & din[WIDTH-1];
        cnt_nx = cnt_ld;
        state_nx = (cnt_ld != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        sr_nx = {fill, sr[WIDTH-1:1]};
        cnt_nx = cnt - CW'(1);
        state_nx = (cnt == CW'(1)) ? DONE : SHIFT;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // DONE is only ever entered from IDLE or SHIFT, so state_nx==DONE marks entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sr <= '0;
      fill <= 1'b0;
      cnt <= '0;
      dout <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      sr <= sr_nx;
      fill <= fill_nx;
      cnt <= cnt_nx;
      dout <= (state_nx == DONE) ? sr_nx : dout;
      busy <= state_nx != IDLE;
      done <= state_nx == DONE;
    end
  end
endmodule

// File: tb/tb_shift_right_seq.sv
// tb_shift_right_seq: directed scoreboard bench for shift_right_seq at WIDTH=4 and WIDTH=8
module tb_shift_right_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start4 = 1'b0, start8 = 1'b0, arith = 1'b0;
  logic [7:0] din = '0;
  logic [3:0] amt = '0;
  logic [3:0] dout4;
  logic [7:0] dout8;
  logic busy4, done4, busy8, done8;
  int checks = 0, errors = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  shift_right_seq #(.WIDTH(4), .AMT_W(2)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .din(din[3:0]), .amt(amt[1:0]),
    .arith(arith), .dout(dout4), .busy(busy4), .done(done4));

  shift_right_seq #(.WIDTH(8), .AMT_W(4)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .din(din), .amt(amt),
    .arith(arith), .dout(dout8), .busy(busy8), .done(done8));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] d, input int a, input logic ar, input int w);
    logic [7:0] r = d;
    logic f = ar & d[w-1];
    int n = (a > w) ? w : a;
    for (int i = 0; i < n; i++) r = (r >> 1) | ({7'b0, f} << (w - 1));
    return r;
  endfunction

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // runs one op on the selected instance and checks latency, busy, dout stability and the pulse
  task automatic op(input string tag, input bit wide, input logic [7:0] d, input int a, input logic ar);
    int w = wide ? 8 : 4;
    int lat = ((a > w) ? w : a) + 1;
    int n = 1;
    logic [7:0] prev = wide ? dout8 : {4'b0, dout4};
    din = d; amt = 4'(a); arith = ar;
    if (wide) start8 = 1'b1; else start4 = 1'b1;
    sb.push_back(model(d, a, ar, w));
    edge1();
    start4 = 1'b0; start8 = 1'b0;
    while (!(wide ? done8 : done4) && n < 20) begin
      chk({tag, "_busy"}, {7'b0, wide ? busy8 : busy4}, 8'd1);
      chk({tag, "_hold"}, wide ? dout8 : {4'b0, dout4}, prev);
      edge1();
      n++;
    end
    chk({tag, "_lat"}, 8'(n), 8'(lat));
    chk({tag, "_done"}, {7'b0, wide ? done8 : done4}, 8'd1);
    chk({tag, "_busyd"}, {7'b0, wide ? busy8 : busy4}, 8'd1);
    chk({tag, "_dout"}, wide ? dout8 : {4'b0, dout4}, sb.pop_front());
    edge1();
    chk({tag, "_pulse"}, {7'b0, wide ? done8 : done4}, 8'd0);
    chk({tag, "_idle"}, {7'b0, wide ? busy8 : busy4}, 8'd0);
  endtask

  initial begin
    int dones;
    #12;
    chk("rst_dout", {4'b0, dout4}, 8'd0);
    chk("rst_busy", {6'b0, busy4, busy8}, 8'd0);
    chk("rst_done", {6'b0, done4, done8}, 8'd0);
    rst_n = 1'b1;
    edge1();
    op("t1", 1'b0, 8'b1011, 2, 1'b0);
    op("t2a", 1'b0, 8'b1011, 2, 1'b1);
    op("t2b", 1'b0, 8'b1011, 3, 1'b1);
    op("t3", 1'b0, 8'b0110, 0, 1'b0);
    op("t3b", 1'b0, 8'b1001, 1, 1'b1);
    // start held high while busy: only the first op counts
    din = 8'b1011; amt = 4'd3; arith = 1'b0; start4 = 1'b1;
    sb.push_back(model(8'b1011, 3, 1'b0, 4));
    dones = 0;
    for (int e = 1; e <= 4; e++) begin
      edge1();
      din = 8'hFF;
      dones += int'(done4);
    end
    start4 = 1'b0;
    chk("t4_done", {7'b0, done4}, 8'd1);
    chk("t4_dout", {4'b0, dout4}, sb.pop_front());
    edge1();
    dones += int'(done4);
    edge1();
    dones += int'(done4);
    chk("t4_count", 8'(dones), 8'd1);
    chk("t4_idle", {7'b0, busy4}, 8'd0);
    chk("t4_keep", {4'b0, dout4}, 8'b0001);
    // async reset in the middle of a shift
    din = 8'b1101; amt = 4'd3; arith = 1'b1; start4 = 1'b1;
    edge1();
    start4 = 1'b0;
    edge1();
    rst_n = 1'b0;
    #1;
    chk("t5_dout", {4'b0, dout4}, 8'd0);
    chk("t5_busy", {7'b0, busy4}, 8'd0);
    chk("t5_done", {7'b0, done4}, 8'd0);
    #2 rst_n = 1'b1;
    dones = 0;
    for (int e = 0; e < 6; e++) begin
      edge1();
      dones += int'(done4) + int'(busy4);
    end
    chk("t5_quiet", 8'(dones), 8'd0);
    op("t6a", 1'b1, 8'h80, 12, 1'b1);
    op("t6b", 1'b1, 8'h80, 12, 1'b0);
    op("t6c", 1'b1, 8'hB4, 3, 1'b1);
    op("t6d", 1'b1, 8'hB4, 8, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
